fpu_dispatch: RTL

FPU_DISPATCH -- requirements
Module: fpu_dispatch

---
 rtl/fpu_pkg.sv | 60 ++++++
 rtl/fpu_cmd_fifo.sv | 80 ++++++++
 rtl/fpu_dispatch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU dispatch slice: opcode constants, the set of
// opcodes whose result lands in the integer register file, the command
// payload struct and the dispatch FSM state type.
// -----------------------------------------------------------------------------
package fpu_pkg;

    // Opcode map of the FPU ctl field. Values 19..31 are unassigned and are
    // forwarded untouched.
    localparam logic [4:0] FADD      = 5'd0;
    localparam logic [4:0] FSUB      = 5'd1;
    localparam logic [4:0] FMUL      = 5'd2;
    localparam logic [4:0] FDIV      = 5'd3;
    localparam logic [4:0] FMIN      = 5'd4;
    localparam logic [4:0] FMAX      = 5'd5;
    localparam logic [4:0] FCVT_W_S  = 5'd6;
    localparam logic [4:0] FCVT_S_W  = 5'd7;
    localparam logic [4:0] FSGNJ     = 5'd8;
    localparam logic [4:0] FEQ       = 5'd9;
    localparam logic [4:0] FLT       = 5'd10;
    localparam logic [4:0] FSGNJN    = 5'd11;
    localparam logic [4:0] FSGNJX    = 5'd12;
    localparam logic [4:0] FLE       = 5'd13;
    localparam logic [4:0] FCLASS    = 5'd14;
    localparam logic [4:0] FMV_X_W   = 5'd15;
    localparam logic [4:0] FCVT_WU_S = 5'd16;
    localparam logic [4:0] FMADD     = 5'd17;
    localparam logic [4:0] FSQR      = 5'd18;

    // One bit per opcode: set where the result is an integer (compare,
    // classify, float-to-int conversion and raw move to the integer file).
    localparam logic [31:0] INT_OP_MASK = (32'd1 << FCVT_W_S)
                                        | (32'd1 << FEQ)
                                        | (32'd1 << FLT)
                                        | (32'd1 << FLE)
                                        | (32'd1 << FCLASS)
                                        | (32'd1 << FMV_X_W)
                                        | (32'd1 << FCVT_WU_S);

    // Command payload carried through the FIFO (the tag is appended by the
    // user, since its width is a module parameter).
    typedef struct packed {
        logic [4:0]  ctl;
        logic [31:0] x1;
        logic [31:0] x2;
    } fpu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } disp_state_t;

    function automatic logic is_int_op(input logic [4:0] ctl);
        return INT_OP_MASK[ctl];
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// fpu_cmd_fifo
// Synchronous FIFO for dispatch commands. Full/empty are registers, so the
// push-side ready has no combinational dependence on the pop side.
//   clk, rst        clock, asynchronous active-high reset
//   i_push, i_wdata write request and data (ignored when full)
//   i_pop           read request (ignored when empty)
//   o_rdata         head entry (valid when !o_empty)
//   o_full, o_empty registered status flags
// -----------------------------------------------------------------------------
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_COUNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries
    // are meaningful, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/fpu_dispatch.sv
// -----------------------------------------------------------------------------
// fpu_dispatch
// Queues FPU commands, issues them one at a time to a single FPU, waits for
// completion (with a timeout abort) and holds the result until writeback
// accepts it.
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                command handshake
//   in_ctl/in_x1/in_x2/in_tag        opcode, operands, destination tag
//   fpu_en                           one-cycle issue strobe
//   fpu_ctl/fpu_x1/fpu_x2            operands, stable until completion
//   fpu_y/fpu_ready                  FPU result and completion strobe
//   out_valid/out_ready              writeback handshake
//   out_data/out_tag/out_is_int      result, tag, integer-destination flag
//   busy                             FSM not idle
//   timeout_err                      sticky: an op was aborted on timeout
// -----------------------------------------------------------------------------
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_ctl,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             fpu_en,
    output logic [4:0]       fpu_ctl,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    input  logic [31:0]      fpu_y,
    input  logic             fpu_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_is_int,
    output logic             busy,
    output logic             timeout_err
);

    localparam int         CMD_W    = $bits(fpu_op_t) + TAG_W;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    disp_state_t      r_state;
    logic             r_fpu_en;
    logic [4:0]       r_fpu_ctl;
    logic [31:0]      r_fpu_x1;
    logic [31:0]      r_fpu_x2;
    logic [TAG_W-1:0] r_tag;
    logic [7:0]       r_cnt;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_is_int;
    logic             r_timeout_err;

    logic [CMD_W-1:0] w_fifo_wdata;
    logic [CMD_W-1:0] w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_start_issue;
    fpu_op_t          w_head_op;
    logic [TAG_W-1:0] w_head_tag;

    assign w_fifo_wdata = {in_ctl, in_x1, in_x2, in_tag};
    assign w_head_op    = fpu_op_t'(w_fifo_rdata[CMD_W-1:TAG_W]);
    assign w_head_tag   = w_fifo_rdata[TAG_W-1:0];

    // The head is consumed during the ISSUE cycle; its contents were already
    // copied into the fpu_* registers on the edge entering ISSUE.
    assign w_pop = (r_state == ST_ISSUE);

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next issue starts from IDLE, or straight from HOLD once the held result
    // is accepted, provided a command is waiting.
    assign w_start_issue = !w_fifo_empty &&
                           ((r_state == ST_IDLE) ||
                            ((r_state == ST_HOLD) && out_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fpu_en      <= 1'b0;
            r_fpu_ctl     <= '0;
            r_fpu_x1      <= '0;
            r_fpu_x2      <= '0;
            r_tag         <= '0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_tag     <= '0;
            r_out_is_int  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_fpu_en <= 1'b0;
            if (w_start_issue) begin
                r_fpu_en  <= 1'b1;
                r_fpu_ctl <= w_head_op.ctl;
                r_fpu_x1  <= w_head_op.x1;
                r_fpu_x2  <= w_head_op.x2;
                r_tag     <= w_head_tag;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_issue) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fpu_ready) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= fpu_y;
                        r_out_tag    <= r_tag;
                        r_out_is_int <= is_int_op(r_fpu_ctl);
                        r_state      <= ST_HOLD;
                    end else if (r_cnt == CNT_LAST) begin
                        // Last allowed WAIT cycle: drop the op silently.
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_start_issue ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = !w_fifo_full;
    assign fpu_en      = r_fpu_en;
    assign fpu_ctl     = r_fpu_ctl;
    assign fpu_x1      = r_fpu_x1;
    assign fpu_x2      = r_fpu_x2;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign out_is_int  = r_out_is_int;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;

endmodule
